arbitro_barramento_rr4: RTL

- Round-robin arbiter that shares one 4-bit bus among 4 requesters.
- The bus is built from the existing 4-way, 4-bit mux (two select lines) and a 1-to-4 enable demux.
- The arbiter drives both mux selects (chave0/chave1) and a one-hot grant that feeds the demux enables.
- It enforces a maximum tenure per grant and a fixed turnaround gap, so two requesters never drive the bus in the same cycle.

---
 rtl/arbitro_barramento_rr4_pkg.sv | 17 +
 rtl/arbitro_barramento_rr4_seletor_prioridade_rr.sv | 31 +++
 rtl/arbitro_barramento_rr4.sv | 115 +++++++++++
 3 files changed

// File: rtl/arbitro_barramento_rr4_pkg.sv
// rtl/arbitro_barramento_rr4_pkg.sv - shared constants and types for the 4-way round-robin bus arbiter
package arbitro_barramento_rr4_pkg;

  localparam int NUM_REQ_BUS = 4;
  localparam int SEL_W       = 2;

  typedef enum logic [1:0] {
    LIVRE     = 2'b00,
    CONCEDIDO = 2'b01,
    LIBERA    = 2'b10
  } estado_t;

  function automatic logic [NUM_REQ_BUS-1:0] onehot(input logic [SEL_W-1:0] i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/arbitro_barramento_rr4_seletor_prioridade_rr.sv
// rtl/arbitro_barramento_rr4_seletor_prioridade_rr.sv - combinational rotating priority encoder
module seletor_prioridade_rr
  import arbitro_barramento_rr4_pkg::*;
(
  input  logic [NUM_REQ_BUS-1:0] req,
  input  logic [SEL_W-1:0]       ponteiro,
  output logic                   valido,
  output logic [SEL_W-1:0]       idx
);

  logic [NUM_REQ_BUS-1:0] rot;
  logic [SEL_W-1:0]       k;
  logic [SEL_W-1:0]       j;

  // Rotate so ponteiro lands on bit 0, pick the lowest set bit, then rotate back.
  always_comb begin
    rot = '0;
    j   = '0;
    for (int i = 0; i < NUM_REQ_BUS; i++) begin
      j      = SEL_W'(i) + ponteiro;
      rot[i] = req[j];
    end
    k = '0;
    for (int i = NUM_REQ_BUS - 1; i >= 0; i--) begin
      if (rot[i]) k = SEL_W'(i);
    end
    valido = |rot;
    idx    = k + ponteiro;
  end

endmodule

// File: rtl/arbitro_barramento_rr4.sv
// rtl/arbitro_barramento_rr4.sv - round-robin bus arbiter with tenure limit and turnaround gap
module arbitro_barramento_rr4
  import arbitro_barramento_rr4_pkg::*;
#(
  parameter int MAX_POSSE = 8,
  parameter int NUM_REQ   = 4
)
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ_BUS-1:0] req,
  input  logic [NUM_REQ_BUS-1:0] fim,
  output logic [NUM_REQ_BUS-1:0] grant,
  output logic                   chave0,
  output logic                   chave1,
  output logic                   ocupado,
  output logic                   expirou
);

  if (NUM_REQ != NUM_REQ_BUS) begin : g_erro_cfg
    $error("arbitro_barramento_rr4: NUM_REQ must be 4");
  end

  localparam int CW = (MAX_POSSE < 2) ? 1 : $clog2(MAX_POSSE + 1);
  localparam logic [CW-1:0] CMAX   = (MAX_POSSE == 0) ? {CW{1'b1}} : CW'(MAX_POSSE);
  localparam logic [CW-1:0] LIMITE = (MAX_POSSE == 0) ? '0 : CW'(MAX_POSSE - 1);

  estado_t                estado_q, estado_d;
  logic [NUM_REQ_BUS-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]       chave_q, chave_d;
  logic                   ocupado_q, ocupado_d;
  logic                   expirou_q, expirou_d;
  logic [SEL_W-1:0]       ponteiro_q, ponteiro_d;
  logic [CW-1:0]          contador_q, contador_d;

  logic                   valido;
  logic [SEL_W-1:0]       idx;
  logic                   rel_a, rel_b, rel_c;

  seletor_prioridade_rr u_seletor (
    .req      (req),
    .ponteiro (ponteiro_q),
    .valido   (valido),
    .idx      (idx)
  );

  always_comb begin
    estado_d   = estado_q;
    grant_d    = grant_q;
    chave_d    = chave_q;
    ocupado_d  = ocupado_q;
    expirou_d  = 1'b0;
    ponteiro_d = ponteiro_q;
    contador_d = contador_q;
    rel_a      = ~req[chave_q];
    rel_b      = fim[chave_q];
    rel_c      = (MAX_POSSE != 0) && (contador_q == LIMITE);
    case (estado_q)
      LIVRE: begin
        if (valido) begin
          estado_d   = CONCEDIDO;
          grant_d    = onehot(idx);
          chave_d    = idx;
          ocupado_d  = 1'b1;
          contador_d = '0;
        end
      end
      CONCEDIDO: begin
        // Selects keep the last owner through release so the mux never glitches.
        if (rel_a || rel_b || rel_c) begin
          estado_d   = LIBERA;
          grant_d    = '0;
          ocupado_d  = 1'b0;
          ponteiro_d = chave_q + 2'd1;
          expirou_d  = rel_c && !rel_a && !rel_b;
        end else if (contador_q != CMAX) begin
          contador_d = contador_q + 1'b1;
        end
      end
      LIBERA: estado_d = LIVRE;
      default: begin
        estado_d  = LIVRE;
        grant_d   = '0;
        ocupado_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= LIVRE;
      grant_q    <= '0;
      chave_q    <= '0;
      ocupado_q  <= 1'b0;
      expirou_q  <= 1'b0;
      ponteiro_q <= '0;
      contador_q <= '0;
    end else begin
      estado_q   <= estado_d;
      grant_q    <= grant_d;
      chave_q    <= chave_d;
      ocupado_q  <= ocupado_d;
      expirou_q  <= expirou_d;
      ponteiro_q <= ponteiro_d;
      contador_q <= contador_d;
    end
  end

  assign grant   = grant_q;
  assign chave0  = chave_q[0];
  assign chave1  = chave_q[1];
  assign ocupado = ocupado_q;
  assign expirou = expirou_q;

endmodule
